time_setter: RTL and testbench

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/timer_pkg.sv | 39 +++
 rtl/key_repeat.sv | 57 +++++
 rtl/time_setter.sv | 164 ++++++++++++++++
 tb/tb_time_setter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the time-setting front end.
package timer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StEditH,
      StEditM,
      StEditS,
      StCommit
   } state_e;

   localparam logic [5:0] HOURS_MAX   = 6'd23;
   localparam logic [5:0] MIN_SEC_MAX = 6'd59;

   // program_led codes, active-low: one lamp per field being edited
   localparam logic [2:0] LED_IDLE   = 3'b111;
   localparam logic [2:0] LED_EDIT_H = 3'b110;
   localparam logic [2:0] LED_EDIT_M = 3'b101;
   localparam logic [2:0] LED_EDIT_S = 3'b011;
   localparam logic [2:0] LED_COMMIT = 3'b111;

   // Increment with wrap; any out-of-range captured value also wraps to 0
   function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] max);
      return (val >= max) ? 6'd0 : val + 6'd1;
   endfunction

   function automatic logic [2:0] led_code(input state_e st);
      logic [2:0] code;
      case (st)
         StEditH:  code = LED_EDIT_H;
         StEditM:  code = LED_EDIT_M;
         StEditS:  code = LED_EDIT_S;
         StCommit: code = LED_COMMIT;
         default:  code = LED_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Press detector for an active-low debounced key, with optional auto-repeat.
// press: one-cycle pulse the cycle after the key is first sampled low.
// rpt:   one-cycle pulse REPEAT_DELAY cycles after press, then every REPEAT_PERIOD while held.
module key_repeat #(
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press,
   output logic rpt
);

   localparam int unsigned CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
   localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] WRAP_C  = CW'(REPEAT_DELAY + REPEAT_PERIOD);

   logic          key_q;
   logic          press_q, press_d;
   logic          rpt_q, rpt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Hold counter: cycles since the press edge; after the delay it cycles DELAY..WRAP-1
   always_comb begin
      press_d = key_q & ~key;
      cnt_d   = '0;
      rpt_d   = 1'b0;
      if (REPEAT_EN && !key && !key_q) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_d == WRAP_C) begin
            cnt_d = DELAY_C;
         end
         rpt_d = (cnt_d == DELAY_C);
      end
   end

   // Key sample and event registers; reset leaves the key released
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_q   <= 1'b1;
         press_q <= 1'b0;
         rpt_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         key_q   <= key;
         press_q <= press_d;
         rpt_q   <= rpt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;
   assign rpt   = rpt_q;

endmodule

// File: rtl/time_setter.sv
// Two-button time-setting controller: mode steps through fields, inc bumps the current one.
module time_setter
   import timer_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 5_000_000,
   parameter int unsigned BLINK_PERIOD  = 12_500_000,
   parameter int unsigned TIMEOUT       = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic [5:0] cur_hours,
   input  logic [5:0] cur_minutes,
   input  logic [5:0] cur_seconds,
   output logic [5:0] set_hours,
   output logic [5:0] set_minutes,
   output logic [5:0] set_seconds,
   output logic       load,
   output logic       editing,
   output logic       blink,
   output logic [2:0] program_led
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned BW = $clog2(BLINK_PERIOD + 1);
   localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);
   localparam logic [BW-1:0] BLINK_C = BW'(BLINK_PERIOD);

   logic mode_press, mode_rpt, inc_press, inc_rpt;

   key_repeat #(
      .REPEAT_EN    (1'b0),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_key_mode (
      .clk  (clk),
      .rst  (rst),
      .key  (key_mode),
      .press(mode_press),
      .rpt  (mode_rpt)
   );

   key_repeat #(
      .REPEAT_EN    (1'b1),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_key_inc (
      .clk  (clk),
      .rst  (rst),
      .key  (key_inc),
      .press(inc_press),
      .rpt  (inc_rpt)
   );

   state_e        state_q, state_d;
   logic [5:0]    hours_q, hours_d, minutes_q, minutes_d, seconds_q, seconds_d;
   logic          load_q, load_d, editing_q, editing_d, blink_q, blink_d;
   logic [2:0]    led_q, led_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          inc_ev, any_ev, in_edit, edit_next, timed_out;

   // Mode wins over a simultaneous inc
   assign inc_ev  = (inc_press | inc_rpt) & ~mode_press;
   assign any_ev  = mode_press | inc_press | inc_rpt | mode_rpt;
   assign in_edit = state_q inside {StEditH, StEditM, StEditS};

   // Next state, edited fields, idle timeout
   always_comb begin
      state_d   = state_q;
      hours_d   = hours_q;
      minutes_d = minutes_q;
      seconds_d = seconds_q;
      tmo_d     = '0;
      timed_out = 1'b0;
      if (in_edit && !any_ev) begin
         tmo_d     = tmo_q + TW'(1);
         timed_out = (tmo_d == TMO_C);
      end
      unique case (state_q)
         StIdle: begin
            if (mode_press) begin
               hours_d   = cur_hours;
               minutes_d = cur_minutes;
               seconds_d = cur_seconds;
               state_d   = StEditH;
            end
         end
         StEditH: begin
            if (mode_press)     state_d = StEditM;
            else if (inc_ev)    hours_d = inc_wrap(hours_q, HOURS_MAX);
            else if (timed_out) state_d = StIdle;
         end
         StEditM: begin
            if (mode_press)     state_d   = StEditS;
            else if (inc_ev)    minutes_d = inc_wrap(minutes_q, MIN_SEC_MAX);
            else if (timed_out) state_d   = StIdle;
         end
         StEditS: begin
            if (mode_press)     state_d   = StCommit;
            else if (inc_ev)    seconds_d = inc_wrap(seconds_q, MIN_SEC_MAX);
            else if (timed_out) state_d   = StIdle;
         end
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Registered outputs derived from the next state; blink restarts on entry from idle
   always_comb begin
      edit_next   = state_d inside {StEditH, StEditM, StEditS};
      editing_d   = edit_next;
      load_d      = (state_d == StCommit);
      led_d       = led_code(state_d);
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      if (edit_next && state_q != StIdle) begin
         blink_cnt_d = blink_cnt_q + BW'(1);
         blink_d     = blink_q;
         if (blink_cnt_d == BLINK_C) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         hours_q     <= '0;
         minutes_q   <= '0;
         seconds_q   <= '0;
         load_q      <= 1'b0;
         editing_q   <= 1'b0;
         blink_q     <= 1'b0;
         led_q       <= LED_IDLE;
         tmo_q       <= '0;
         blink_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hours_q     <= hours_d;
         minutes_q   <= minutes_d;
         seconds_q   <= seconds_d;
         load_q      <= load_d;
         editing_q   <= editing_d;
         blink_q     <= blink_d;
         led_q       <= led_d;
         tmo_q       <= tmo_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign set_hours   = hours_q;
   assign set_minutes = minutes_q;
   assign set_seconds = seconds_q;
   assign load        = load_q;
   assign editing     = editing_q;
   assign blink       = blink_q;
   assign program_led = led_q;

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: direct checks plus a scoreboard of expected committed times.
module tb_time_setter;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_mode, key_inc;
   logic [5:0] cur_hours, cur_minutes, cur_seconds;
   logic [5:0] set_hours, set_minutes, set_seconds;
   logic       load, editing, blink;
   logic [2:0] program_led;

   int n_checks = 0;
   int n_fail   = 0;
   int n_loads  = 0;
   logic [17:0] sb_q[$];
   logic [17:0] sb_exp;

   time_setter #(
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(4),
      .BLINK_PERIOD (4),
      .TIMEOUT      (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_mode   (key_mode),
      .key_inc    (key_inc),
      .cur_hours  (cur_hours),
      .cur_minutes(cur_minutes),
      .cur_seconds(cur_seconds),
      .set_hours  (set_hours),
      .set_minutes(set_minutes),
      .set_seconds(set_seconds),
      .load       (load),
      .editing    (editing),
      .blink      (blink),
      .program_led(program_led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each press: one cycle low, then release; outputs reflect it when the task returns
   task automatic press_mode();
      key_mode = 1'b0;
      tick();
      key_mode = 1'b1;
      tick();
   endtask

   task automatic press_inc();
      key_inc = 1'b0;
      tick();
      key_inc = 1'b1;
      tick();
   endtask

   task automatic press_both();
      key_mode = 1'b0;
      key_inc  = 1'b0;
      tick();
      key_mode = 1'b1;
      key_inc  = 1'b1;
      tick();
   endtask

   task automatic set_cur(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
      cur_hours   = h;
      cur_minutes = m;
      cur_seconds = s;
   endtask

   task automatic push_exp(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
      sb_q.push_back({h, m, s});
   endtask

   // Load monitor: every load pulse must match the next expected commit
   always @(negedge clk) begin
      if (load === 1'b1) begin
         n_loads++;
         if (sb_q.size() == 0) begin
            check("load_unexpected", 32'(load), 32'd0);
         end else begin
            sb_exp = sb_q.pop_front();
            check("load_set", 32'({set_hours, set_minutes, set_seconds}), 32'(sb_exp));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      key_mode = 1'b1;
      key_inc  = 1'b1;
      set_cur(6'd0, 6'd0, 6'd0);
      repeat (3) tick();
      check("rst_load", 32'(load), 32'd0);
      check("rst_editing", 32'(editing), 32'd0);
      check("rst_blink", 32'(blink), 32'd0);
      check("rst_led", 32'(program_led), 32'b111);
      check("rst_set", 32'({set_hours, set_minutes, set_seconds}), 32'd0);
      rst = 1'b1;
      tick();

      // inc in idle is ignored
      set_cur(6'd3, 6'd4, 6'd5);
      press_inc();
      check("idle_inc_editing", 32'(editing), 32'd0);
      check("idle_inc_set", 32'({set_hours, set_minutes, set_seconds}), 32'd0);

      // Full edit: 12:34:56 -> 14:35:56
      set_cur(6'd12, 6'd34, 6'd56);
      press_mode();
      check("t1_led_h", 32'(program_led), 32'b110);
      check("t1_editing", 32'(editing), 32'd1);
      check("t1_blink_entry", 32'(blink), 32'd0);
      check("t1_capture", 32'({set_hours, set_minutes, set_seconds}),
            32'({6'd12, 6'd34, 6'd56}));
      press_inc();
      press_inc();
      check("t1_hours", 32'(set_hours), 32'd14);
      press_mode();
      check("t1_led_m", 32'(program_led), 32'b101);
      press_inc();
      check("t1_minutes", 32'(set_minutes), 32'd35);
      press_mode();
      check("t1_led_s", 32'(program_led), 32'b011);
      push_exp(6'd14, 6'd35, 6'd56);
      press_mode();
      check("t1_load_pulse", 32'(load), 32'd1);
      check("t1_led_commit", 32'(program_led), 32'b111);
      check("t1_commit_editing", 32'(editing), 32'd0);
      tick();
      check("t1_load_end", 32'(load), 32'd0);
      check("t1_hold", 32'({set_hours, set_minutes, set_seconds}),
            32'({6'd14, 6'd35, 6'd56}));

      // Wrap boundaries: 23 -> 0 and 59 -> 0
      set_cur(6'd23, 6'd0, 6'd59);
      press_mode();
      press_inc();
      check("t2_hours_wrap", 32'(set_hours), 32'd0);
      press_mode();
      press_mode();
      press_inc();
      check("t2_seconds_wrap", 32'(set_seconds), 32'd0);
      push_exp(6'd0, 6'd0, 6'd0);
      press_mode();
      tick();

      // Out-of-range capture wraps to 0
      set_cur(6'd40, 6'd59, 6'd59);
      press_mode();
      check("t2_capture_40", 32'(set_hours), 32'd40);
      press_inc();
      check("t2_hours_40", 32'(set_hours), 32'd0);
      press_mode();
      press_inc();
      check("t2_minutes_wrap", 32'(set_minutes), 32'd0);
      press_mode();
      push_exp(6'd0, 6'd0, 6'd59);
      press_mode();
      tick();

      // Auto-repeat in EDIT_M: increments at press, +8 and +12 cycles
      set_cur(6'd5, 6'd10, 6'd0);
      press_mode();
      press_mode();
      check("t3_start", 32'(set_minutes), 32'd10);
      key_inc = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (k == 1)  check("t3_press", 32'(set_minutes), 32'd11);
         if (k == 8)  check("t3_before_rpt", 32'(set_minutes), 32'd11);
         if (k == 9)  check("t3_rpt1", 32'(set_minutes), 32'd12);
         if (k == 12) check("t3_before_rpt2", 32'(set_minutes), 32'd12);
         if (k == 13) check("t3_rpt2", 32'(set_minutes), 32'd13);
      end
      key_inc = 1'b1;
      repeat (20) tick();
      check("t3_after_release", 32'(set_minutes), 32'd13);
      press_mode();
      push_exp(6'd5, 6'd13, 6'd0);
      press_mode();
      tick();

      // Simultaneous mode+inc: mode wins, inc dropped
      set_cur(6'd7, 6'd8, 6'd9);
      press_mode();
      press_both();
      check("t4_led", 32'(program_led), 32'b101);
      check("t4_hours", 32'(set_hours), 32'd7);
      press_mode();
      push_exp(6'd7, 6'd8, 6'd9);
      press_mode();
      tick();

      // Blink and timeout in EDIT_H
      set_cur(6'd1, 6'd2, 6'd3);
      press_mode();
      repeat (3) tick();
      check("t5_blink_low", 32'(blink), 32'd0);
      tick();
      check("t5_blink_high", 32'(blink), 32'd1);
      repeat (59) tick();
      check("t5_pre_timeout", 32'(editing), 32'd1);
      tick();
      check("t5_timeout_editing", 32'(editing), 32'd0);
      check("t5_timeout_led", 32'(program_led), 32'b111);
      check("t5_timeout_blink", 32'(blink), 32'd0);
      check("t5_timeout_set", 32'({set_hours, set_minutes, set_seconds}),
            32'({6'd1, 6'd2, 6'd3}));

      // Reset during EDIT_S
      set_cur(6'd9, 6'd9, 6'd9);
      press_mode();
      press_mode();
      press_mode();
      check("t6_led_s", 32'(program_led), 32'b011);
      rst = 1'b0;
      tick();
      check("t6_set", 32'({set_hours, set_minutes, set_seconds}), 32'd0);
      check("t6_editing", 32'(editing), 32'd0);
      check("t6_led", 32'(program_led), 32'b111);
      check("t6_blink", 32'(blink), 32'd0);
      check("t6_load", 32'(load), 32'd0);
      rst = 1'b1;
      tick();

      // Reset while the commit press is in flight: no load
      press_mode();
      press_mode();
      press_mode();
      key_mode = 1'b0;
      tick();
      rst      = 1'b0;
      key_mode = 1'b1;
      tick();
      check("t6b_load", 32'(load), 32'd0);
      rst = 1'b1;
      repeat (5) tick();
      check("t6b_editing", 32'(editing), 32'd0);

      check("load_count", 32'(n_loads), 32'd5);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
